// File: rtl/pipeline_register_elastic.sv
// Elastic pipeline register: DEPTH two-entry skid slices in series with
// registered ready, synchronous flush and a live occupancy count.
module pipeline_register_elastic #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } slot_state_e;

  logic [DEPTH-1:0]  main_valid;
  logic [DEPTH-1:0]  skid_valid;
  logic [DEPTH-1:0]  up_valid;
  logic [DEPTH-1:0]  down_ready;
  logic [DATA_W-1:0] main_data [DEPTH];
  logic [DATA_W-1:0] up_data   [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
      slot_state_e       state_reg;
      slot_state_e       state_next;
      logic [DATA_W-1:0] main_data_reg;
      logic [DATA_W-1:0] main_data_next;
      logic [DATA_W-1:0] skid_data_reg;
      logic [DATA_W-1:0] skid_data_next;
      logic              accept_in;
      logic              accept_out;

      if (gi == 0) begin : g_head
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
      end else begin : g_link
        assign up_valid[gi] = main_valid[gi-1];
        assign up_data[gi]  = main_data[gi-1];
      end

      // Downstream ready is the next slice's registered !skid_valid.
      if (gi == DEPTH-1) begin : g_tail
        assign down_ready[gi] = out_ready;
      end else begin : g_mid
        assign down_ready[gi] = !skid_valid[gi+1];
      end

      assign main_valid[gi] = (state_reg != EMPTY);
      assign skid_valid[gi] = (state_reg == FULL);
      assign main_data[gi]  = main_data_reg;

      assign accept_in  = up_valid[gi] && !skid_valid[gi];
      assign accept_out = main_valid[gi] && down_ready[gi];

      always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        case (state_reg)
          EMPTY: begin
            if (accept_in) begin
              main_data_next = up_data[gi];
              state_next     = ONE;
            end
          end
          ONE: begin
            if (accept_in && accept_out) begin
              main_data_next = up_data[gi];
            end else if (accept_in) begin
              skid_data_next = up_data[gi];
              state_next     = FULL;
            end else if (accept_out) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            if (accept_out) begin
              main_data_next = skid_data_reg;
              state_next     = ONE;
            end
          end
          default: state_next = EMPTY;
        endcase
        // Flush only drops valid bits; data registers keep their contents.
        if (flush) begin
          state_next = EMPTY;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg     <= EMPTY;
          main_data_reg <= '0;
          skid_data_reg <= '0;
        end else begin
          state_reg     <= state_next;
          main_data_reg <= main_data_next;
          skid_data_reg <= skid_data_next;
        end
      end
    end
  endgenerate

  assign in_ready  = !skid_valid[0];
  assign out_valid = main_valid[DEPTH-1];
  assign out_data  = main_data[DEPTH-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(main_valid[i]) + CNT_W'(skid_valid[i]);
    end
  end

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Scoreboard bench: three instances (DEPTH 1,2,3); directed cases on DEPTH=2,
// then random traffic with flushes on all three against a FIFO reference.
module tb_pipeline_register_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [3];
  logic        fl   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ov   [3];
  logic [31:0] idat [3];
  logic [31:0] odat [3];
  logic [7:0]  cnt  [3];

  logic [31:0] exp_q [3][$];
  int          pops  [3];
  bit          clr   [3];
  bit          held_v[3];
  logic [31:0] held_d[3];
  bit          mon_en;
  bit          verbose;
  int          errors;
  int          checks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int D = gi + 1;
      logic [$clog2(2*D+1)-1:0] cw;

      pipeline_register_elastic #(.DATA_W(32), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (fl[gi]),
        .in_valid  (iv[gi]),
        .in_ready  (irdy[gi]),
        .in_data   (idat[gi]),
        .out_valid (ov[gi]),
        .out_ready (ordy[gi]),
        .out_data  (odat[gi]),
        .count     (cw)
      );
      assign cnt[gi] = 8'(cw);

      // Stimulus side: record each accepted beat; a flush empties the model.
      initial begin
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (fl[gi]) clr[gi] = 1'b1;
            else if (iv[gi] && irdy[gi]) exp_q[gi].push_back(idat[gi]);
          end
          @(posedge clk);
          #1;
          if (clr[gi]) begin
            exp_q[gi].delete();
            clr[gi] = 1'b0;
          end
        end
      end

      // Monitor: compare every consumed beat, stall stability and occupancy.
      initial begin : mon
        logic [31:0] e;
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (held_v[gi]) begin
              chk($sformatf("stall_valid_d%0d", D), 32'(ov[gi]), 32'd1);
              chk($sformatf("stall_data_d%0d", D), odat[gi], held_d[gi]);
            end
            if (ov[gi] && ordy[gi]) begin
              pops[gi]++;
              checks++;
              if (exp_q[gi].size() == 0) begin
                errors++;
                $display("FAIL out_beat_d%0d: got %h, required no beat", D, odat[gi]);
              end else begin
                e = exp_q[gi].pop_front();
                if (odat[gi] !== e) begin
                  errors++;
                  $display("FAIL out_beat_d%0d: got %h, required %h", D, odat[gi], e);
                end else if (verbose) begin
                  $display("txn depth=%0d out=%h", D, odat[gi]);
                end
              end
            end
            held_v[gi] = ov[gi] && !ordy[gi] && !fl[gi];
            held_d[gi] = odat[gi];
          end
          @(posedge clk);
          #2;
          if (mon_en) begin
            chk($sformatf("count_d%0d", D), 32'(cnt[gi]), 32'(exp_q[gi].size()));
            if (exp_q[gi].size() == 2*D) chk($sformatf("full_ready_d%0d", D), 32'(irdy[gi]), 32'd0);
            if (exp_q[gi].size() == 0) begin
              chk($sformatf("empty_valid_d%0d", D), 32'(ov[gi]), 32'd0);
              chk($sformatf("empty_ready_d%0d", D), 32'(irdy[gi]), 32'd1);
            end
          end
        end
      end
    end
  endgenerate

  initial begin
    int n;
    int p0;
    bit ok_a;
    bit ok_b;
    int pct;
    errors  = 0;
    checks  = 0;
    mon_en  = 1'b0;
    verbose = 1'b1;
    rst     = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; fl[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0;
      clr[d] = 1'b0; held_v[d] = 1'b0; held_d[d] = '0; pops[d] = 0;
    end
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", 32'(ov[d]), 32'd0);
      chk("reset_ready", 32'(irdy[d]), 32'd1);
      chk("reset_count", 32'(cnt[d]), 32'd0);
      chk("reset_data", odat[d], 32'd0);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    // Single-beat latency on DEPTH=2
    step(); iv[1] = 1'b1; idat[1] = 32'hDEADBEEF; ordy[1] = 1'b1;
    step(); iv[1] = 1'b0;
    #2;
    chk("lat_edge0_valid", 32'(ov[1]), 32'd0);
    chk("lat_edge0_count", 32'(cnt[1]), 32'd1);
    step(); #2;
    chk("lat_edge1_valid", 32'(ov[1]), 32'd1);
    chk("lat_edge1_data", odat[1], 32'hDEADBEEF);
    step(); #2;
    chk("lat_edge2_count", 32'(cnt[1]), 32'd0);

    // Full-rate stream 0..99
    ok_a = 1'b1; ok_b = 1'b1; p0 = pops[1];
    for (int i = 0; i < 100; i++) begin
      step();
      iv[1] = 1'b1; idat[1] = 32'(i); ordy[1] = 1'b1;
      if (!irdy[1]) ok_a = 1'b0;
      if (i >= 2 && !ov[1]) ok_b = 1'b0;
    end
    step(); iv[1] = 1'b0;
    repeat (4) step();
    chk("stream_ready_high", 32'(ok_a), 32'd1);
    chk("stream_one_per_cycle", 32'(ok_b), 32'd1);
    chk("stream_beats", 32'(pops[1] - p0), 32'd100);

    // Backpressure fill and drain
    n = 0; ordy[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      iv[1] = 1'b1; idat[1] = 32'h10 + 32'(n);
      @(negedge clk);
      if (irdy[1]) n++;
    end
    step(); iv[1] = 1'b0;
    #2;
    chk("bp_accepted", 32'(n), 32'd4);
    chk("bp_ready_low", 32'(irdy[1]), 32'd0);
    chk("bp_count", 32'(cnt[1]), 32'd4);
    ordy[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(ov[1]), 32'd1);
      chk("bp_drain_data", odat[1], 32'h10 + 32'(j));
    end
    step(); #2;
    chk("bp_drained_count", 32'(cnt[1]), 32'd0);

    // Flush with an incoming beat
    ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); iv[1] = 1'b1; idat[1] = 32'h20 + 32'(k);
    end
    step();
    chk("flush_pre_count", 32'(cnt[1]), 32'd3);
    iv[1] = 1'b1; idat[1] = 32'hAA; fl[1] = 1'b1;
    step(); fl[1] = 1'b0; iv[1] = 1'b0;
    #2;
    chk("flush_count", 32'(cnt[1]), 32'd0);
    chk("flush_valid", 32'(ov[1]), 32'd0);
    ordy[1] = 1'b1; ok_a = 1'b1; p0 = pops[1];
    repeat (6) begin
      step();
      if (ov[1]) ok_a = 1'b0;
    end
    chk("flush_no_output", 32'(ok_a), 32'd1);
    chk("flush_no_pops", 32'(pops[1] - p0), 32'd0);

    // Reset mid-stream
    ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); iv[1] = 1'b1; idat[1] = 32'h30 + 32'(k);
    end
    step(); iv[1] = 1'b0;
    #2;
    chk("rstm_pre_count", 32'(cnt[1]), 32'd3);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstm_valid", 32'(ov[1]), 32'd0);
    chk("rstm_ready", 32'(irdy[1]), 32'd1);
    chk("rstm_count", 32'(cnt[1]), 32'd0);
    chk("rstm_data", odat[1], 32'd0);
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      clr[d] = 1'b0;
      held_v[d] = 1'b0;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    // Random traffic with occasional flushes on all depths
    verbose = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      step();
      case ((c / 700) % 3)
        0:       pct = 90;
        1:       pct = 50;
        default: pct = 15;
      endcase
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom_range(0, 99) < 65);
        idat[d] = $urandom;
        ordy[d] = ($urandom_range(0, 99) < pct);
        fl[d]   = ($urandom_range(0, 299) == 0);
      end
    end
    step();
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; fl[d] = 1'b0; ordy[d] = 1'b1;
    end
    repeat (12) step();
    for (int d = 0; d < 3; d++) begin
      chk("drain_queue_empty", 32'(exp_q[d].size()), 32'd0);
      chk("drain_count", 32'(cnt[d]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_register_elastic.md
# pipeline_register_elastic

Parametrised elastic pipeline register for the pipelined RISC-V core: the successor to the fixed per-boundary stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed payload through DEPTH register slices with a valid/ready handshake and a synchronous flush. Each slice is a two-entry skid buffer, so ready is registered and throughput is one beat per cycle under backpressure. Control fields such as RegWrite, ResultSrc, Rd and PC+4 are packed by the instantiating stage into `in_data`.

## Interface
- DATA_W, 32: payload width in bits; minimum 1.
- DEPTH, 1: number of skid slices in series; minimum 1.
- CNT_W, $clog2(2*DEPTH+1): width of `count`; derived, never overridden.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  a beat is presented downstream.
- out_ready  input  1  downstream accepts a beat this cycle.
- out_data  output  DATA_W  downstream payload.
- count  output  CNT_W  number of valid entries held, from 0 to 2*DEPTH.

## Operation
- Each slice k holds a main entry (valid, data) and a skid entry (valid, data).
- Slice k output: valid = main_valid[k], data = main_data[k].
- Slice k input ready = !skid_valid[k]. This is registered, so there is no combinational ready path between slices.
- Slice 0 input connects to `in_*`. Slice DEPTH-1 output connects to `out_*`. Slice k output feeds slice k+1 input.
- Handshake terms:
  - Accept-in: input valid && input ready.
  - Accept-out: output valid && output ready.
- Slice states and transitions:
  - EMPTY (main 0, skid 0):
    - accept-in → main ← input, go to ONE.
  - ONE (main 1, skid 0):
    - accept-in and accept-out → main ← input, stay in ONE.
    - accept-in only → skid ← input, go to FULL.
    - accept-out only → go to EMPTY.
  - FULL (main 1, skid 1), input ready = 0:
    - accept-out → main ← skid, skid_valid ← 0, go to ONE.
- Ordering: beats leave in arrival order. No beat is lost or duplicated.
- Flush:
  - On a rising edge with flush=1, every main_valid and skid_valid clears to 0.
  - Flush overrides all accepts in that cycle.
  - A beat presented with in_valid=1 and in_ready=1 during flush is discarded.
  - A beat shown on out_* during flush is treated as consumed if out_ready=1.
  - Data registers are not cleared.
- count = popcount of all main and skid valid bits. It is computed combinationally from registered state only.
- Payload is opaque: no arithmetic, no width change, all DATA_W bits pass through unaltered.

## Timing
- Reset (rst=0) acts immediately, without waiting for a clock edge:
  - All valid bits are 0 and all data registers are 0.
  - out_valid=0, out_data=0, in_ready=1, count=0.
  - Reset applied mid-stream drops every held beat.
- Release of rst is synchronised by the integrating top. The first accept can occur on the first rising edge after release.
- Latency: a beat accepted at edge N into an empty block appears on out_* after edge N+DEPTH-1, i.e. it is visible in cycle N+DEPTH.
- Throughput: one beat per cycle whenever out_ready=1 continuously.
- in_ready falls only when slice 0 is FULL. With out_ready held at 0, exactly 2*DEPTH beats are accepted before in_ready falls.
- After out_ready rises, in_ready recovers one edge after slice 0 drains its skid entry.
- Simultaneous accept-in and accept-out in ONE keeps occupancy constant, so count is unchanged.
- out_data is stable while out_valid=1 and out_ready=0.

## Test plan
- **Reset mid-stream.** DEPTH=2, load 3 beats, then drive rst=0 between edges → same cycle: out_valid=0, in_ready=1, count=0, out_data=0.
- **Single-beat latency.** DEPTH=2, in_data=0xDEADBEEF accepted at edge 0, out_ready=1 → out_valid=1 with 0xDEADBEEF after edge 1, and count returns to 0 after edge 2.
- **Full-rate stream.** DEPTH=2, stream 0..99 with out_ready=1 → in_ready never 0, one output per cycle, 0..99 in order.
- **Backpressure fill and drain.** DEPTH=2, out_ready=0, continuous in_valid with 0x10,0x11,… → exactly 4 accepted, then in_ready=0 and count=4. Raise out_ready → 0x10..0x13 out in 4 consecutive cycles, with no loss and no duplicates.
- **Flush.** count=3, flush=1 with in_valid=1 (in_data=0xAA) → after the edge: count=0, out_valid=0, and 0xAA never appears at the output.
- **Random backpressure.** Random in_valid and out_ready over 10k cycles, DEPTH=1 and DEPTH=3, checked against a scoreboard → order preserved, count equals the scoreboard occupancy, out_data stable while stalled.
